// File: rtl/ika2151_pkg.sv
// rtl/ika2151_pkg.sv - shared constants for the IKA2151 timer scheduler
package ika2151_pkg;

    localparam int TC_LOAD_A  = 0;
    localparam int TC_LOAD_B  = 1;
    localparam int TC_IRQEN_A = 2;
    localparam int TC_IRQEN_B = 3;
    localparam int TC_FRST_A  = 4;
    localparam int TC_FRST_B  = 5;
    localparam int TC_W       = 6;

    localparam int TA_W = 10;
    localparam int TB_W = 8;

    localparam int TB_PRESCALE_DEF = 16;

endpackage

// File: rtl/ika2151_timer_cnt.sv
// rtl/ika2151_timer_cnt.sv - preload/increment/overflow up-counter shared by Timer A and B
module ika2151_timer_cnt #(
    parameter int W = 10
) (
    input  logic         i_EMUCLK,
    input  logic         i_MRST_n,
    input  logic         en,
    input  logic         step,
    input  logic         load,
    input  logic [W-1:0] init,
    output logic         ovfl
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = W'(1);

    logic [W-1:0] cnt;

    // Combinational so the top can register flag/pulse on the same en edge.
    assign ovfl = en & step & load & (cnt == CNT_MAX);

    always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            cnt <= '0;
        end else if (en && step) begin
            if (!load || ovfl) begin
                cnt <= init;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/ika2151_timer_sched.sv
// rtl/ika2151_timer_sched.sv - Timer A/B scheduler: prescaler, status flags, IRQ and CSM overflow pulse
module ika2151_timer_sched
    import ika2151_pkg::*;
#(
    parameter int TB_PRESCALE = TB_PRESCALE_DEF
) (
    input  logic            i_EMUCLK,
    input  logic            i_MRST_n,
    input  logic            i_phi1_PCEN_n,
    input  logic            i_phi1_NCEN_n,
    input  logic            i_CYCLE_31,
    input  logic [7:0]      i_CLKA1,
    input  logic [1:0]      i_CLKA2,
    input  logic [7:0]      i_CLKB,
    input  logic [TC_W-1:0] i_TIMERCTRL,
    input  logic            i_TIMERCTRL_WR,
    output logic            o_TIMERA_FLAG,
    output logic            o_TIMERB_FLAG,
    output logic            o_TIMERA_OVFL,
    output logic            o_IRQ_n
);

    localparam int              PW       = $clog2(TB_PRESCALE);
    localparam logic [PW-1:0]   PRE_LAST = PW'(TB_PRESCALE - 1);
    localparam logic [PW-1:0]   PRE_ONE  = PW'(1);

    logic          en;
    logic          tick;
    logic          btick;
    logic [PW-1:0] presc;
    logic          ovfl_a;
    logic          ovfl_b;
    logic          set_a, set_b;
    logic          clr_a, clr_b;
    logic          flag_a_nx, flag_b_nx;
    logic          unused_pcen;

    assign unused_pcen = i_phi1_PCEN_n;

    assign en    = ~i_phi1_NCEN_n;
    assign tick  = en & i_CYCLE_31;
    assign btick = tick & (presc == PRE_LAST);

    // Free-running sample prescaler; LOAD_B never touches it.
    always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            presc <= '0;
        end else if (tick) begin
            presc <= presc + PRE_ONE;
        end
    end

    ika2151_timer_cnt #(.W(TA_W)) u_timer_a (
        .i_EMUCLK (i_EMUCLK),
        .i_MRST_n (i_MRST_n),
        .en       (en),
        .step     (tick),
        .load     (i_TIMERCTRL[TC_LOAD_A]),
        .init     ({i_CLKA1, i_CLKA2}),
        .ovfl     (ovfl_a)
    );

    ika2151_timer_cnt #(.W(TB_W)) u_timer_b (
        .i_EMUCLK (i_EMUCLK),
        .i_MRST_n (i_MRST_n),
        .en       (en),
        .step     (btick),
        .load     (i_TIMERCTRL[TC_LOAD_B]),
        .init     (i_CLKB),
        .ovfl     (ovfl_b)
    );

    assign set_a = ovfl_a & i_TIMERCTRL[TC_IRQEN_A];
    assign set_b = ovfl_b & i_TIMERCTRL[TC_IRQEN_B];
    assign clr_a = i_TIMERCTRL_WR & i_TIMERCTRL[TC_FRST_A];
    assign clr_b = i_TIMERCTRL_WR & i_TIMERCTRL[TC_FRST_B];

    // Set dominates clear so an overflow coinciding with a reset write is kept.
    assign flag_a_nx = set_a | (o_TIMERA_FLAG & ~clr_a);
    assign flag_b_nx = set_b | (o_TIMERB_FLAG & ~clr_b);

    always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            o_TIMERA_FLAG <= 1'b0;
            o_TIMERB_FLAG <= 1'b0;
            o_IRQ_n       <= 1'b1;
            o_TIMERA_OVFL <= 1'b0;
        end else if (en) begin
            o_TIMERA_FLAG <= flag_a_nx;
            o_TIMERB_FLAG <= flag_b_nx;
            o_IRQ_n       <= ~(flag_a_nx | flag_b_nx);
            if (tick) begin
                o_TIMERA_OVFL <= ovfl_a;
            end
        end
    end

endmodule

// File: tb/tb_ika2151_timer_sched.sv
// tb/tb_ika2151_timer_sched.sv - scoreboard bench for the Timer A/B scheduler
module tb_ika2151_timer_sched;

    logic       clk;
    logic       rst_n;
    logic       pcen_n;
    logic       ncen_n;
    logic       c31;
    logic [7:0] clka1;
    logic [1:0] clka2;
    logic [7:0] clkb;
    logic [5:0] tctrl;
    logic       wr;
    logic       flag_a, flag_b, ovfl, irq_n;

    int checks = 0;
    int errors = 0;
    int tcnt   = 0;
    int slot   = 0;
    bit mon_en = 0;

    typedef struct {
        int         t;
        logic [3:0] v;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    ika2151_timer_sched #(.TB_PRESCALE(16)) dut (
        .i_EMUCLK       (clk),
        .i_MRST_n       (rst_n),
        .i_phi1_PCEN_n  (pcen_n),
        .i_phi1_NCEN_n  (ncen_n),
        .i_CYCLE_31     (c31),
        .i_CLKA1        (clka1),
        .i_CLKA2        (clka2),
        .i_CLKB         (clkb),
        .i_TIMERCTRL    (tctrl),
        .i_TIMERCTRL_WR (wr),
        .o_TIMERA_FLAG  (flag_a),
        .o_TIMERB_FLAG  (flag_b),
        .o_TIMERA_OVFL  (ovfl),
        .o_IRQ_n        (irq_n)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // phi1 enable every other EMUCLK, 32-slot frame
    initial begin
        ncen_n = 1;
        c31    = 0;
        forever begin
            @(negedge clk);
            if (ncen_n) begin
                ncen_n = 0;
                c31    = (slot == 31);
            end else begin
                ncen_n = 1;
                c31    = 0;
                slot   = (slot + 1) % 32;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (!ncen_n && c31) tcnt++;
        end
    end

    // Monitor: every change of {ovfl, flag_a, flag_b, irq_n} must match the queue head
    initial begin
        logic [3:0] prev, cur;
        exp_t       e;
        wait (mon_en);
        prev = 4'b0001;
        forever begin
            @(posedge clk);
            #1;
            cur = {ovfl, flag_a, flag_b, irq_n};
            if (cur !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got ovfl/fa/fb/irq_n=%b at sample %0d, expected no change", cur, tcnt);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e.v || tcnt != e.t) begin
                        errors++;
                        $display("FAIL %s: got ovfl/fa/fb/irq_n=%b at sample %0d, expected %b at sample %0d",
                                 e.name, cur, tcnt, e.v, e.t);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic push(input int t, input logic [3:0] v, input string name);
        exp_t e;
        e.t = t;
        e.v = v;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, expv);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_irq_n"},  irq_n,  1'b1);
        chk({tag, "_flag_a"}, flag_a, 1'b0);
        chk({tag, "_flag_b"}, flag_b, 1'b0);
        chk({tag, "_ovfl"},   ovfl,   1'b0);
    endtask

    task automatic at_slot(input int s);
        do begin
            @(negedge clk);
            #1;
        end while (!(ncen_n == 1'b0 && slot == s));
    endtask

    task automatic slot_after(input int s, input int t);
        do at_slot(s); while (tcnt < t);
    endtask

    task automatic write_ctrl(input logic [5:0] v);
        tctrl = v;
        wr    = 1;
        @(posedge clk);
        #1;
        wr    = 0;
    endtask

    initial begin
        int t0, m0, p0, q0, u0, s0, bn, r0;
        rst_n  = 1;
        pcen_n = 1;
        clka1  = 0;
        clka2  = 0;
        clkb   = 0;
        tctrl  = 0;
        wr     = 0;

        #23 rst_n = 0;
        #1 check_reset("reset_init");
        repeat (6) @(negedge clk);
        #3 rst_n = 1;
        r0 = tcnt;
        mon_en = 1;

        // Timer A period 4, flag set, then set-vs-clear priority
        at_slot(5);
        clka1 = 8'hFF; clka2 = 2'd0;
        write_ctrl(6'b000100);
        at_slot(5);
        t0 = tcnt;
        write_ctrl(6'b000101);
        push(t0 + 4,  4'b1100, "a_ovfl1");
        push(t0 + 5,  4'b0100, "a_ovfl1_end");
        push(t0 + 8,  4'b1100, "a_ovfl2");
        push(t0 + 9,  4'b0100, "a_ovfl2_end");
        push(t0 + 12, 4'b1100, "prio_set_wins");
        push(t0 + 13, 4'b0100, "prio_ovfl_end");
        slot_after(31, t0 + 11);
        write_ctrl(6'b010101);
        slot_after(5, t0 + 13);
        push(t0 + 13, 4'b0001, "frst_a_clear");
        write_ctrl(6'b010100);

        // Masked: NA=1023 overflows every sample, flag stays clear
        at_slot(5);
        clka1 = 8'hFF; clka2 = 2'd3;
        write_ctrl(6'b000000);
        at_slot(5);
        m0 = tcnt;
        write_ctrl(6'b000001);
        push(m0 + 1, 4'b1001, "mask_ovfl");
        push(m0 + 4, 4'b0001, "mask_stop");
        slot_after(5, m0 + 3);
        write_ctrl(6'b000000);

        // Stop mid-count, reload NA=1000, then reset mid-count
        at_slot(5);
        clka1 = 8'hFF; clka2 = 2'd0;
        write_ctrl(6'b000100);
        at_slot(5);
        p0 = tcnt;
        write_ctrl(6'b000101);
        slot_after(5, p0 + 2);
        clka1 = 8'd250; clka2 = 2'd0;
        write_ctrl(6'b000100);
        at_slot(5);
        q0 = tcnt;
        write_ctrl(6'b000101);
        push(q0 + 24, 4'b1100, "reload_ovfl");
        slot_after(5, q0 + 24);
        push(q0 + 24, 4'b0001, "reset_event");
        #2 rst_n = 0;
        #1 check_reset("reset_mid");
        tctrl = 6'b000000;
        repeat (5) @(negedge clk);
        #3 rst_n = 1;
        r0 = tcnt;
        repeat (6) at_slot(5);
        at_slot(5);
        u0 = tcnt;
        write_ctrl(6'b000001);
        push(u0 + 24, 4'b1001, "post_reset_ovfl");
        push(u0 + 25, 4'b0001, "post_reset_ovfl_end");
        slot_after(5, u0 + 25);
        write_ctrl(6'b000000);

        // Timer B: NB=254, period 32 samples with prescale 16
        at_slot(5);
        clkb = 8'd254;
        write_ctrl(6'b001000);
        s0 = tcnt;
        bn = r0 + 16 * ((s0 - r0) / 16 + 1);
        slot_after(5, bn);
        write_ctrl(6'b001010);
        push(bn + 32, 4'b0010, "b_first");
        slot_after(5, bn + 32);
        push(bn + 32, 4'b0001, "b_clear");
        write_ctrl(6'b101010);
        push(bn + 64, 4'b0010, "b_period");
        slot_after(5, bn + 64);
        write_ctrl(6'b000000);
        slot_after(5, bn + 65);
        push(bn + 65, 4'b0001, "b_frst_only");
        write_ctrl(6'b100000);

        repeat (4) at_slot(5);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending events expected 0 (next %s)", exp_q.size(), exp_q[0].name);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
